regfile_writeback: RTL and testbench

Write-back sequencer that owns the single write port of the 32x32 RISC-V register file. It merges single-cycle ALU results, which have no backpressure, with load results from the memory unit through a valid/ready handshake and a small FIFO. It drives `writeRegister`/`writeData`/`regWrite` into the register file and publishes a pending-register scoreboard for the hazard logic.

---
 rtl/regfile_writeback.sv | 95 +++++++++
 tb/tb_regfile_writeback.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
`default_nettype none
// regfile_writeback: owns the register-file write port, merging ALU results with FIFO-buffered load results.
// Revision 1.0
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [4:0]              mem_rd,
  input  logic [XLEN-1:0]         mem_data,
  output logic [4:0]              writeRegister,
  output logic [XLEN-1:0]         writeData,
  output logic                    regWrite,
  output logic [31:0]             pending,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  logic alu_hit;
  logic push;
  logic pop;

  // Writes to x0 are architecturally void, so they neither occupy the port nor the FIFO.
  assign alu_hit    = alu_valid && (alu_rd != 5'd0);
  assign mem_ready  = (count < FULL);
  assign push       = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign pop        = !alu_hit && (count != '0);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_vld      <= '0;
      regWrite      <= 1'b0;
      writeRegister <= 5'd0;
      writeData     <= '0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= mem_rd;
        fifo_data[wr_ptr] <= mem_data;
        fifo_vld[wr_ptr]  <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // ALU has strict priority; rd/data hold their last value when idle.
      regWrite <= alu_hit || pop;
      if (alu_hit) begin
        writeRegister <= alu_rd;
        writeData     <= alu_data;
      end else if (pop) begin
        writeRegister <= fifo_rd[rd_ptr];
        writeData     <= fifo_data[rd_ptr];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) pending[fifo_rd[i]] = 1'b1;
    end
    if (regWrite) pending[writeRegister] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// tb_regfile_writeback: random + directed stimulus against a queue-based reference model with a write scoreboard.
// Revision 1.0
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  bit               clk = 1'b0;
  logic             rst_n;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic [XLEN-1:0]  mem_data;
  logic [4:0]       writeRegister;
  logic [XLEN-1:0]  writeData;
  logic             regWrite;
  logic [31:0]      pending;
  logic [$clog2(DEPTH):0] fifo_count;

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] data;} ent_t;
  typedef struct {int cyc; logic [4:0] rd; logic [XLEN-1:0] data;} exp_t;

  ent_t            mq[$];
  exp_t            sb[$];
  bit              m_vld;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  bit              last_acc;
  int              cyc = 0;
  int              checks = 0;
  int              failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    if (m_vld) p[m_rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Advance one clock; the model consumes the inputs that were applied across this edge.
  task automatic step();
    bit   acc;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); sb.delete();
      m_vld = 1'b0; m_rd = '0; m_data = '0; last_acc = 1'b0;
    end else begin
      acc = mem_valid && (mq.size() < DEPTH);
      last_acc = acc;
      if (alu_valid && alu_rd != 5'd0) begin
        m_vld = 1'b1; m_rd = alu_rd; m_data = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_vld = 1'b1; m_rd = e.rd; m_data = e.data;
      end else begin
        m_vld = 1'b0;
      end
      if (acc && mem_rd != 5'd0) mq.push_back('{rd: mem_rd, data: mem_data});
      if (m_vld) sb.push_back('{cyc: cyc + 1, rd: m_rd, data: m_data});
    end
    cyc++;
    #1;
  endtask

  task automatic drive(bit av, logic [4:0] ard, logic [XLEN-1:0] ad,
                       bit mv, logic [4:0] mrd, logic [XLEN-1:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, '0, 0, 5'd0, '0);
  endtask

  task automatic rnd_inputs();
    alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
    mem_valid = 1'($urandom); mem_rd = 5'($urandom); mem_data = $urandom;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, and checks visible state.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      x = sb.pop_front();
      chk("regWrite_expected", regWrite, 1);
      chk("write_rd", writeRegister, x.rd);
      chk("write_data", writeData, x.data);
    end else begin
      chk("regWrite_idle", regWrite, 0);
    end
    chk("writeRegister_hold", writeRegister, m_rd);
    chk("writeData_hold", writeData, m_data);
    chk("fifo_count", fifo_count, mq.size());
    chk("mem_ready", mem_ready, (mq.size() < DEPTH));
    chk("pending", pending, model_pending());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    // Reset with activity on every input.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin rnd_inputs(); step(); end
    chk("rst_regWrite", regWrite, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_pending", pending, 0);
    rst_n = 1'b1;
    idle(2);

    // Single ALU write, then a discarded x0 write.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0);
    chk("alu_write_rd", writeRegister, 5);
    chk("alu_write_data", writeData, 32'hDEADBEEF);
    chk("alu_pending5", pending[5], 1);
    drive(1, 5'd0, 32'h1234, 0, 5'd0, '0);
    chk("alu_x0_nowrite", regWrite, 0);
    idle(2);

    // Uncontended load.
    drive(0, 5'd0, '0, 1, 5'd7, 32'hCAFE);
    chk("load_pending7_c1", pending[7], 1);
    idle(1);
    chk("load_write_rd", writeRegister, 7);
    chk("load_write_data", writeData, 32'hCAFE);
    idle(3);

    // Sustained ALU traffic while five loads are offered.
    k = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(i % 31 + 1), $urandom, k < 5, 5'(10 + k), 32'hA000 + k);
      if (last_acc) k++;
    end
    chk("fill_count", fifo_count, 4);
    chk("fill_ready", mem_ready, 0);
    chk("fill_accepted", k, 4);
    while (k < 5) begin
      drive(0, 5'd0, '0, 1, 5'(10 + k), 32'hA000 + k);
      if (last_acc) k++;
    end
    idle(8);

    // Pointer wrap: alternating push/pop.
    for (int i = 0; i < 40; i++)
      drive(0, 5'd0, '0, (i % 2) == 0, 5'($urandom_range(1, 31)), $urandom);
    idle(2);
    chk("wrap_count", fifo_count, 0);

    // Push plus ALU with two entries queued.
    for (int i = 0; i < 2; i++) drive(1, 5'd3, $urandom, 1, 5'(20 + i), $urandom);
    drive(1, 5'd4, 32'h44, 1, 5'd22, 32'h22);
    chk("simul_count", fifo_count, 3);
    chk("simul_alu_first", writeRegister, 4);
    idle(1);
    chk("simul_head_pops", writeRegister, 20);
    idle(4);

    // Reset with three queued entries.
    for (int i = 0; i < 3; i++) drive(1, 5'd2, $urandom, 1, 5'(25 + i), $urandom);
    rst_n = 1'b0; rnd_inputs(); step();
    chk("midrst_count", fifo_count, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_regWrite", regWrite, 0);
    rst_n = 1'b1;
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      rnd_inputs();
      step();
    end
    rst_n = 1'b1;
    idle(DEPTH + 4);
    chk("drained_scoreboard", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
